alu_serial_seq: RTL and testbench

- Bit-serial ALU sequencer that sits directly upstream of the 1-bit ALU slice and drives it.
- Accepts a W-bit operand pair and a 3-bit op on a start strobe.
- Feeds one bit pair per clock, LSB first, through an internal 1-bit slice, holding the carry in a flip-flop between bits.
- Shifts the slice output into a result register and reports result, carry, overflow and zero flags with a one-cycle done pulse.

---
 rtl/alu_serial_pkg.sv | 30 +++
 rtl/alu_bit_slice.sv | 45 ++++
 rtl/alu_serial_seq.sv | 137 +++++++++++++
 tb/tb_alu_serial_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM
// state encoding and small sizing/decode helpers.
package alu_serial_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index WIDTH bit positions (0..WIDTH-1); never below 1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  // ADD and SUB are the only ops that use the carry chain and produce flags.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice. B is inverted for SUB so that the
// sequencer only has to preset the carry to 1; logic ops never carry.
module alu_bit_slice
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       y,
  output logic       cout
);

  logic b_eff_s;

  // Per-bit function select; full adder for ADD/SUB, bitwise gate otherwise.
  always_comb begin
    b_eff_s = b;
    y       = 1'b0;
    cout    = 1'b0;
    if (op == OP_SUB) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD,
      OP_SUB: begin
        y    = a ^ b_eff_s ^ cin;
        cout = (a & b_eff_s) | (a & cin) | (b_eff_s & cin);
      end
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_NAND: y = ~(a & b);
      OP_XNOR: y = ~(a ^ b);
      default: begin
        y    = 1'b0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer. Captures an operand pair and op on start,
// walks the bits LSB first through one alu_bit_slice with the carry held
// in a flop, then publishes result and flags with a one-cycle done pulse.
// busy/done are registered from the current state, so they trail the FSM
// by one cycle: busy covers the bit-processing edges, done follows the
// DONE cycle, and the two can never be high together.
module alu_serial_seq
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             cin_msb_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             zero_r;

  logic             y_s;
  logic             cout_s;

  alu_bit_slice u_slice (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .op   (op_r),
    .y    (y_s),
    .cout (cout_s)
  );

  // Sequencer FSM with operand/result shifting and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_sh_r    <= '0;
      op_r        <= 3'd0;
      cnt_r       <= '0;
      carry_r     <= 1'b0;
      cin_msb_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      busy_r <= (state_r == RUN);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r    <= a;
            b_sh_r    <= b;
            op_r      <= op;
            res_sh_r  <= '0;
            cnt_r     <= '0;
            carry_r   <= (op == OP_SUB);
            cin_msb_r <= 1'b0;
            state_r   <= RUN;
          end else begin
            state_r   <= IDLE;
          end
        end
        RUN: begin
          res_sh_r <= {y_s, res_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r  <= cout_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_BIT) begin
            // Carry into the MSB is what the carry flop holds for this bit.
            cin_msb_r <= carry_r;
            state_r   <= DONE;
          end else begin
            state_r   <= RUN;
          end
        end
        DONE: begin
          result_r    <= res_sh_r;
          carry_out_r <= is_arith(op_r) ? carry_r : 1'b0;
          overflow_r  <= is_arith(op_r) ? (cin_msb_r ^ carry_r) : 1'b0;
          zero_r      <= (res_sh_r == '0);
          if (start) begin
            a_sh_r    <= a;
            b_sh_r    <= b;
            op_r      <= op;
            res_sh_r  <= '0;
            cnt_r     <= '0;
            carry_r   <= (op == OP_SUB);
            cin_msb_r <= 1'b0;
            state_r   <= RUN;
          end else begin
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign overflow  = overflow_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed testbench for alu_serial_seq (WIDTH=8). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;

  int vec_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) overlap_cnt++;
  end

  // Pulse start for exactly one rising edge (edge 0 of the operation).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Advance edge by edge until done is seen or the bound expires.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #12;
    vec_cnt++;
    if ({busy, done, result, carry_out, overflow, zero} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h c=%b v=%b z=%b, want all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // ADD/SUB flag corners and each logic op, one full operation per entry.
  task automatic test_ops();
    logic [2:0]   t_op  [10] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [W-1:0] t_a   [10] = '{8'h7F, 8'hFF, 8'h05, 8'h80, 8'hC3, 8'h00, 8'h3C, 8'h00, 8'hC3, 8'hAA};
    logic [W-1:0] t_b   [10] = '{8'h01, 8'h01, 8'h05, 8'h01, 8'h0F, 8'h00, 8'h0F, 8'h00, 8'h0F, 8'h55};
    logic [W-1:0] t_res [10] = '{8'h80, 8'h00, 8'h00, 8'h7F, 8'h03, 8'h00, 8'h33, 8'hFF, 8'hFC, 8'h00};
    logic [2:0]   t_flg [10] = '{3'b010, 3'b101, 3'b101, 3'b110, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b001};
    int n;
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done(n);
      vec_cnt++;
      if (n !== 9) begin
        err_cnt++;
        $display("FAIL op%0d_latency: done after %0d edges, want 9", i, n);
      end
      vec_cnt++;
      if (result !== t_res[i]) begin
        err_cnt++;
        $display("FAIL op%0d_result: got %h, want %h", i, result, t_res[i]);
      end
      vec_cnt++;
      if ({carry_out, overflow, zero} !== t_flg[i]) begin
        err_cnt++;
        $display("FAIL op%0d_flags: got c/v/z=%b%b%b, want %b", i, carry_out, overflow, zero, t_flg[i]);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (done !== 1'b0 || result !== t_res[i]) begin
        err_cnt++;
        $display("FAIL op%0d_pulse_hold: got done=%b result=%h, want done=0 result=%h",
                 i, done, result, t_res[i]);
      end
    end
  endtask

  // start re-pulsed during RUN with different operands must be ignored.
  task automatic test_start_ignored();
    int n;
    int extra;
    issue(3'd4, 8'hA5, 8'hFF);
    repeat (2) begin @(posedge clk); #1; end
    op = 3'd0; a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    vec_cnt++;
    if (n !== 6) begin
      err_cnt++;
      $display("FAIL ignore_latency: done after %0d more edges, want 6", n);
    end
    vec_cnt++;
    if (result !== 8'h5A || carry_out !== 1'b0 || overflow !== 1'b0 || zero !== 1'b0) begin
      err_cnt++;
      $display("FAIL ignore_result: got %h c=%b v=%b z=%b, want 5a 0 0 0", result, carry_out, overflow, zero);
    end
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    vec_cnt++;
    if (extra !== 0 || result !== 8'h5A) begin
      err_cnt++;
      $display("FAIL ignore_single_done: got %0d extra done, result %h, want 0 and 5a", extra, result);
    end
  endtask

  // start held high into DONE queues an OR straight after an ADD.
  task automatic test_back_to_back();
    int n;
    issue(3'd2, 8'h10, 8'h20);
    repeat (4) begin @(posedge clk); #1; end
    op = 3'd1; a = 8'h0F; b = 8'hF0; start = 1'b1;
    wait_done(n);
    start = 1'b0;
    vec_cnt++;
    if (n !== 5 || result !== 8'h30) begin
      err_cnt++;
      $display("FAIL b2b_first: got %0d edges result %h, want 5 edges result 30", n, result);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (busy !== 1'b1 || done !== 1'b0 || result !== 8'h30) begin
      err_cnt++;
      $display("FAIL b2b_rerun: got busy=%b done=%b result=%h, want 1 0 30", busy, done, result);
    end
    wait_done(n);
    vec_cnt++;
    if (n !== 8) begin
      err_cnt++;
      $display("FAIL b2b_latency: second done %0d edges after first, want 9", n + 1);
    end
    vec_cnt++;
    if (result !== 8'hFF || zero !== 1'b0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      err_cnt++;
      $display("FAIL b2b_second: got %h z=%b c=%b v=%b, want ff 0 0 0", result, zero, carry_out, overflow);
    end
    @(posedge clk); #1;
  endtask

  // Reset asserted mid-RUN aborts the op with no done; a fresh op then works.
  task automatic test_reset_mid_run();
    int n;
    int seen;
    issue(3'd2, 8'h01, 8'h01);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({busy, done, result, carry_out, overflow, zero} !== 13'd0) begin
      err_cnt++;
      $display("FAIL midrun_reset: got busy=%b done=%b result=%h c=%b v=%b z=%b, want all 0",
               busy, done, result, carry_out, overflow, zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    vec_cnt++;
    if (seen !== 0) begin
      err_cnt++;
      $display("FAIL midrun_abort: got %0d busy/done cycles after reset, want 0", seen);
    end
    issue(3'd2, 8'h01, 8'h01);
    wait_done(n);
    vec_cnt++;
    if (n !== 9 || result !== 8'h02 || {carry_out, overflow, zero} !== 3'b000) begin
      err_cnt++;
      $display("FAIL midrun_restart: got %0d edges result %h c/v/z=%b%b%b, want 9 02 000",
               n, result, carry_out, overflow, zero);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    vec_cnt++;
    if (overlap_cnt !== 0) begin
      err_cnt++;
      $display("FAIL busy_done_overlap: got %0d cycles with both high, want 0", overlap_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
